// File: rtl/gpc_uart_tx.sv
// Memory-mapped 8N1 serial transmitter for the gpc_cpu bus: a byte FIFO feeds a
// start/data/stop shifter whose bit period is set by a programmable baud divider.
`timescale 1ns/1ps

module gpc_uart_tx #(
    parameter logic [15:0] BASE        = 16'h6000,
    parameter int          DEPTH       = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] address,
    inout  wire  [7:0]  data,
    input  logic        rw,
    output logic        tx,
    output logic        tx_busy
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    logic          rw_q;
    logic [15:0]   wr_addr_q;
    logic [7:0]    wr_data_q;
    logic [15:0]   div_q;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [4:0]    count_q;
    logic          overflow_q;
    state_e        state_q;
    logic [15:0]   baud_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;

    logic          commit;
    logic          wr_hit;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic          rd_en;
    logic [7:0]    rdata;

    // A bus write is committed on the falling edge of rw, using the address
    // and data captured while rw was high, so a long pulse commits only once.
    // NOTE: every clocked block uses non-blocking (<=) so all registers update
    // from the same pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q      <= 1'b0;
            wr_addr_q <= 16'h0000;
            wr_data_q <= 8'h00;
        end else begin
            rw_q <= rw;
            if (rw) begin
                wr_addr_q <= address;
                wr_data_q <= data;
            end
        end
    end

    assign commit     = rw_q && !rw;
    assign wr_hit     = commit && (wr_addr_q[15:2] == BASE[15:2]);
    assign push_req   = wr_hit && (wr_addr_q[1:0] == 2'd0);
    assign fifo_empty = (count_q == 5'd0);
    assign fifo_full  = (count_q == DEPTH_C);

    // A byte leaves the FIFO whenever a new frame begins, from idle or straight out of a stop bit.
    assign pop     = !fifo_empty &&
                     ((state_q == S_IDLE) || (state_q == S_STOP && baud_q == 16'h0000));
    assign push_ok = push_req && (!fifo_full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= DEFAULT_DIV;
        end else if (wr_hit && wr_addr_q[1:0] == 2'd2) begin
            div_q[7:0] <= wr_data_q;
        end else if (wr_hit && wr_addr_q[1:0] == 2'd3) begin
            div_q[15:8] <= wr_data_q;
        end
    end

    // NOTE: the FIFO storage array has no reset; pointers and count alone
    // decide which entries are valid, so clearing the data would be wasted logic.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wr_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= 5'd0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop)     rptr_q <= rptr_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 5'd1;
                2'b01:   count_q <= count_q - 5'd1;
                default: count_q <= count_q;
            endcase
            if (wr_hit && wr_addr_q[1:0] == 2'd1) begin
                overflow_q <= 1'b0;
            end else if (push_req && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            baud_q    <= 16'h0000;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rptr_q];
                        baud_q  <= div_q;
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (baud_q == 16'h0000) begin
                        baud_q    <= div_q;
                        bit_idx_q <= 3'd0;
                        tx_q      <= shift_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_q == 16'h0000) begin
                        baud_q <= div_q;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                S_STOP: begin
                    if (baud_q == 16'h0000) begin
                        if (pop) begin
                            shift_q <= mem_q[rptr_q];
                            baud_q  <= div_q;
                            tx_q    <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_en = (address[15:2] == BASE[15:2]) && !rw;

    // NOTE: rdata gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        rdata = 8'h00;
        case (address[1:0])
            2'd1:    rdata = {count_q[3:0], overflow_q, fifo_empty, fifo_full, state_q != S_IDLE};
            2'd2:    rdata = div_q[7:0];
            2'd3:    rdata = div_q[15:8];
            default: rdata = 8'h00;
        endcase
    end

    assign data    = rd_en ? rdata : 8'hzz;
    assign tx      = tx_q;
    assign tx_busy = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_gpc_uart_tx.sv
// Directed bench for gpc_uart_tx: register reads, frame timing, back-to-back
// frames, FIFO overflow, mid-bit divider change and mid-frame reset.
`timescale 1ns/1ps

module tb_gpc_uart_tx;

    localparam logic [15:0] BASE = 16'h6000;

    logic        clk;
    logic        rst_n;
    logic [15:0] address;
    logic        rw;
    logic        tx;
    logic        tx_busy;
    logic [7:0]  tb_drv;
    logic        tb_en;
    tri1  [7:0]  data;

    int checks   = 0;
    int failures = 0;

    assign data = tb_en ? tb_drv : 8'hzz;

    gpc_uart_tx dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .address (address),
        .data    (data),
        .rw      (rw),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts at the next falling edge, holds rw high for 'hold' cycles; returns
    // just before the commit edge.
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int hold);
        @(negedge clk);
        address = a;
        tb_drv  = d;
        tb_en   = 1'b1;
        rw      = 1'b1;
        repeat (hold) @(negedge clk);
        rw    = 1'b0;
        tb_en = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] v);
        address = a;
        rw      = 1'b0;
        tb_en   = 1'b0;
        #1;
        v = data;
    endtask

    logic [7:0]  rd;
    logic [63:0] v;
    logic [63:0] vb;
    logic        ones;
    logic        found;
    logic        busy_last;

    initial begin
        rst_n   = 1'b0;
        address = 16'h0000;
        rw      = 1'b0;
        tb_en   = 1'b0;
        tb_drv  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        bus_read(BASE + 16'd1, rd); check("rst_status", rd, 8'h04);
        bus_read(BASE + 16'd2, rd); check("rst_divlo", rd, 8'h67);
        bus_read(BASE + 16'd3, rd); check("rst_divhi", rd, 8'h00);
        bus_read(BASE + 16'd0, rd); check("txdata_reads_zero", rd, 8'h00);
        bus_read(16'h8000, rd);     check("no_drive_outside", rd, 8'hFF);

        // Write just outside the window must not start a frame.
        bus_write(16'h6004, 8'h55, 1);
        ones = 1'b1;
        repeat (4) begin @(negedge clk); ones &= tx; end
        check("outside_write_busy", tx_busy, 1'b0);
        check("outside_write_tx", ones, 1'b1);

        // Single frame, DIV=3, long rw pulse.
        bus_write(BASE + 16'd2, 8'h03, 1);
        bus_write(BASE + 16'd3, 8'h00, 1);
        bus_write(BASE + 16'd0, 8'hA5, 3);
        @(negedge clk);
        check("t2_tx_high_at_commit", tx, 1'b1);
        v = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            v = {v[62:0], tx};
        end
        check("t2_frame_a5", v, 64'h0F0F00F0FF);
        @(negedge clk);
        check("t2_busy_after", tx_busy, 1'b0);
        ones = 1'b1;
        repeat (12) begin @(negedge clk); ones &= tx; end
        check("t2_single_frame", ones, 1'b1);

        // Back-to-back frames with DIV=0.
        bus_write(BASE + 16'd2, 8'h00, 1);
        v = '0;
        found = 1'b0;
        busy_last = 1'b0;
        fork
            begin
                bus_write(BASE + 16'd0, 8'h01, 1);
                bus_write(BASE + 16'd0, 8'h02, 1);
                bus_write(BASE + 16'd0, 8'h03, 1);
                @(negedge clk);
                bus_read(BASE + 16'd1, rd);
                check("t3_status_count2", rd, 8'h21);
            end
            begin
                for (int i = 0; i < 20 && !found; i++) begin
                    @(negedge clk);
                    if (tx == 1'b0) found = 1'b1;
                end
                v = {63'd0, tx};
                for (int i = 0; i < 29; i++) begin
                    @(negedge clk);
                    v = {v[62:0], tx};
                end
                busy_last = tx_busy;
            end
        join
        check("t3_start_seen", found, 1'b1);
        check("t3_stream", v, 64'(30'b0100000001_0010000001_0110000001));
        check("t3_busy_last_stop", busy_last, 1'b1);
        @(negedge clk);
        check("t3_busy_fall", tx_busy, 1'b0);

        // FIFO fill and overflow with a very slow divider.
        bus_write(BASE + 16'd2, 8'hFF, 1);
        bus_write(BASE + 16'd3, 8'hFF, 1);
        for (int i = 0; i < 9; i++) bus_write(BASE, 8'(8'h10 + i), 1);
        @(negedge clk);
        bus_read(BASE + 16'd1, rd); check("t4_full_no_ovf", rd, 8'h83);
        check("t4_busy", tx_busy, 1'b1);
        bus_write(BASE, 8'hEE, 1);
        @(negedge clk);
        bus_read(BASE + 16'd1, rd); check("t4_overflow", rd, 8'h8B);
        bus_write(BASE + 16'd1, 8'h00, 1);
        @(negedge clk);
        bus_read(BASE + 16'd1, rd); check("t4_ovf_cleared", rd, 8'h83);
        bus_read(BASE + 16'd3, rd); check("t4_divhi", rd, 8'hFF);

        // Reset in the middle of a frame.
        check("t6_mid_frame_tx", tx, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_tx", tx, 1'b1);
        check("t6_rst_busy", tx_busy, 1'b0);
        bus_read(BASE + 16'd1, rd); check("t6_rst_status", rd, 8'h04);
        @(negedge clk);
        rst_n = 1'b1;
        ones = 1'b1;
        repeat (50) begin @(negedge clk); ones &= tx; end
        check("t6_no_residual", ones, 1'b1);
        check("t6_busy_after", tx_busy, 1'b0);
        bus_read(BASE + 16'd2, rd); check("t6_div_default", rd, 8'h67);

        // Divider change from 3 to 7 during data bit 2.
        bus_write(BASE + 16'd2, 8'h03, 1);
        bus_write(BASE + 16'd0, 8'hA5, 1);
        v  = '0;
        vb = '0;
        fork
            begin
                repeat (12) @(negedge clk);
                bus_write(BASE + 16'd2, 8'h07, 1);
            end
            begin
                for (int i = 0; i < 17; i++) begin
                    @(negedge clk);
                    v = {v[62:0], tx};
                end
                for (int i = 0; i < 48; i++) begin
                    @(negedge clk);
                    vb = {vb[62:0], tx};
                end
            end
        join
        check("t5_bits_0_to_2", v, 64'(17'b1_0000_1111_0000_1111));
        check("t5_bits_3_to_stop", vb, 64'h0000FF00FFFF);
        @(negedge clk);
        check("t5_busy_after", tx_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpc_uart_tx.md
Name: gpc_uart_tx

Overview:
- Memory-mapped serial transmitter on the gpc_cpu bus, downstream of the CPU.
- Decodes `address`, `rw` and the bidirectional `data` bus, and buffers written bytes in a FIFO.
- Shifts bytes out as 8N1 frames on `tx`, and returns status and divider values on CPU reads.
- Gives programs a console output channel without CPU-side timing loops.

Parameters:
- BASE, 16'h6000, base of a 4-byte register window; the low 2 address bits are ignored for match.
- DEPTH, 8, FIFO entries (power of two, 2..16).
- DEFAULT_DIV, 16'd103, reset value of the baud divider; bit period = DIV+1 clocks.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- address  input  16  CPU address bus.
- data  inout  8  CPU data bus; driven only during a selected read, else 8'bZ.
- rw  input  1  CPU bus direction: 1 = CPU write, 0 = read.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  high while a frame is in progress or the FIFO is non-empty.

Behaviour:
- Register map (offset = address[1:0], selected when address[15:2]==BASE[15:2]):
  - 0 TXDATA (W): push byte. Reads as 8'h00.
  - 1 STATUS (R): {count[3:0], overflow, fifo_empty, fifo_full, shifting}. Any write clears overflow.
  - 2 DIVLO (R/W): divider bits 7:0.
  - 3 DIVHI (R/W): divider bits 15:8.
- Read path: combinational. data = register value while sel && rw==0, else Z. No read side effects.
- Write capture:
  - Every posedge with rw==1 registers wr_addr and wr_data.
  - The write commits at the first posedge where rw==0 and the previous sample was rw==1, using the registered address and data.
  - Address match is checked on wr_addr.
  - Exactly one commit per rw high pulse, however long the pulse.
- FIFO:
  - Push on a committed TXDATA write. Pop when the FSM leaves IDLE.
  - Push while full: byte dropped, overflow set (sticky).
  - Simultaneous push and pop: both take effect, count unchanged. This applies when full as well; a pop in the same cycle frees space and the push is accepted.
  - Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty at a posedge, pop into the shift register, load the baud counter with DIV, and go to START. tx drives 0 from that edge.
  - START, DATA, STOP: each bit is held for DIV+1 clocks. The baud counter decrements to 0, then reloads from the current DIV. A divider write takes effect at the next bit boundary.
  - DATA: 8 bits, LSB first, bit index 0..7.
  - STOP: tx=1 for one bit period. Then go directly to START if the FIFO is non-empty (back-to-back frames, no idle gap), else IDLE.
- DIV=0 gives 1 clock per bit.
- Latency: commit at posedge N with the FSM in IDLE → tx falls at posedge N+1.
- tx_busy = (state!=IDLE) || !fifo_empty. The STATUS `shifting` bit = (state!=IDLE).
- Reset (asynchronous, any time including mid-frame):
  - tx=1, tx_busy=0, state IDLE.
  - FIFO empty with pointers 0, overflow 0, DIV=DEFAULT_DIV.
  - Write-capture history cleared to rw-low.
  - data released to Z.
- Addresses outside the window: no commit, no drive.

Test Plan:
- Reset with rw=0: tx=1, tx_busy=0. Read BASE+1 → 8'h04; read BASE+2/3 → 8'h67/8'h00; data=Z at address 16'h8000.
- Write DIVLO=8'h03, DIVHI=8'h00, then TXDATA=8'hA5 (rw held high 3 cycles) → exactly one frame, 4 clocks/bit. tx sequence 0,1,0,1,0,0,1,0,1,1 (start, A5 LSB-first, stop); tx falls 1 clock after the commit edge.
- DIV=0, write 3 bytes 8'h01,8'h02,8'h03 back-to-back → 30 contiguous bit-clocks with no idle between frames. STATUS count reads 2 after the first pop; tx_busy falls after the last stop bit.
- DIV=16'hFFFF, write 9 bytes with DEPTH=8 → first byte popped; bytes 2–9 fill the FIFO to count 8, fifo_full=1, overflow=0. Write a 10th byte → dropped, overflow=1. Write STATUS → overflow=0.
- Change DIV from 3 to 7 in the middle of data bit 2 → bit 2 stays 4 clocks; bit 3 onward are 8 clocks.
- Assert rst_n=0 in the middle of a frame → tx=1 immediately, tx_busy=0, count=0. After release, no residual frame is transmitted.
